// File: rtl/config_slot_loader_if.sv
// SPI flash pins plus the outgoing configuration word stream of the slot loader.
interface config_slot_loader_if;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (
        output sclk, cs_n, mosi, cfg_data, cfg_valid,
        input  miso, cfg_ready
    );

    modport slave (
        input  sclk, cs_n, mosi, cfg_data, cfg_valid,
        output miso, cfg_ready
    );
endinterface

// File: rtl/config_slot_loader.sv
// Reads a slot bitstream from SPI flash (read cmd 0x03, header, payload words) and streams
// the payload as 32-bit configuration words with a valid/ready handshake.
module config_slot_loader #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned SLOT_SHIFT = 16,
    parameter logic [15:0] MAGIC      = 16'hFAB5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_mode,
    input  logic                        i_trigger,
    input  logic [3:0]                  i_slot,
    config_slot_loader_if.master        io_bus,
    output logic                        o_busy,
    output logic                        o_configured,
    output logic                        o_error
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StHdr, StData, StPush, StDone, StErr} state_e;

    state_e            r_state, w_state;
    logic              r_trig_q;
    logic [DivW-1:0]   r_div, w_div;
    logic              r_sclk, w_sclk;
    logic [5:0]        r_bit, w_bit;
    logic [31:0]       r_tx, w_tx;
    logic [31:0]       r_rx, w_rx;
    logic [15:0]       r_cnt, w_cnt;
    logic              r_cs_n, w_cs_n;
    logic              r_mosi, w_mosi;
    logic [31:0]       r_cfg_data, w_cfg_data;
    logic              r_cfg_valid, w_cfg_valid;
    logic              r_busy, w_busy;
    logic              r_configured, w_configured;
    logic              r_error, w_error;

    logic [23:0]       w_addr;
    logic [31:0]       w_cmd;
    logic [31:0]       w_rx_shift;
    logic              w_start, w_shifting, w_half_end, w_rise, w_fall;

    assign w_addr     = {20'd0, i_slot} << SLOT_SHIFT;
    assign w_cmd      = {8'h03, w_addr};
    assign w_rx_shift = {r_rx[30:0], io_bus.miso};
    assign w_start    = i_trigger && !r_trig_q && (r_state == StIdle) && i_mode;
    assign w_shifting = (r_state == StCmd) || (r_state == StHdr) || (r_state == StData);
    assign w_half_end = (r_div == DivLast);
    assign w_rise     = w_shifting && w_half_end && !r_sclk;
    assign w_fall     = w_shifting && w_half_end && r_sclk;

    always_comb begin
        w_state      = r_state;
        w_div        = r_div;
        w_sclk       = r_sclk;
        w_bit        = r_bit;
        w_tx         = r_tx;
        w_rx         = r_rx;
        w_cnt        = r_cnt;
        w_cs_n       = r_cs_n;
        w_mosi       = r_mosi;
        w_cfg_data   = r_cfg_data;
        w_cfg_valid  = r_cfg_valid;
        w_busy       = r_busy;
        w_configured = r_configured;
        w_error      = r_error;

        // Shared SCLK generator: low half then high half, miso captured on each rise.
        if (w_shifting) begin
            w_div = w_half_end ? '0 : r_div + 1'b1;
            if (w_half_end) w_sclk = ~r_sclk;
            if (w_rise) begin
                w_rx  = w_rx_shift;
                w_bit = r_bit + 6'd1;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state      = StCmd;
                    w_cs_n       = 1'b0;
                    w_busy       = 1'b1;
                    w_configured = 1'b0;
                    w_error      = 1'b0;
                    w_div        = '0;
                    w_sclk       = 1'b0;
                    w_bit        = 6'd0;
                    w_rx         = 32'd0;
                    w_mosi       = w_cmd[31];
                    w_tx         = {w_cmd[30:0], 1'b0};
                end
            end
            StCmd: begin
                if (w_fall) begin
                    if (r_bit == 6'd32) begin
                        w_state = StHdr;
                        w_mosi  = 1'b0;
                        w_bit   = 6'd0;
                    end else begin
                        w_mosi = r_tx[31];
                        w_tx   = {r_tx[30:0], 1'b0};
                    end
                end
            end
            StHdr: begin
                if (w_fall && (r_bit == 6'd32)) begin
                    w_bit = 6'd0;
                    if ((r_rx[31:16] != MAGIC) || (r_rx[15:0] == 16'd0)) begin
                        w_state = StErr;
                    end else begin
                        w_cnt   = r_rx[15:0];
                        w_state = StData;
                    end
                end
            end
            StData: begin
                // The last rise of a word goes straight to PUSH; SCLK is pulled low there.
                if (w_rise && (r_bit == 6'd31)) begin
                    w_state     = StPush;
                    w_cfg_data  = w_rx_shift;
                    w_cfg_valid = 1'b1;
                    w_div       = '0;
                    w_bit       = 6'd0;
                end
            end
            StPush: begin
                w_sclk = 1'b0;
                if (io_bus.cfg_ready) begin
                    w_cfg_valid = 1'b0;
                    w_cnt       = r_cnt - 16'd1;
                    w_state     = (r_cnt == 16'd1) ? StDone : StData;
                end
            end
            StDone: begin
                w_cs_n       = 1'b1;
                w_busy       = 1'b0;
                w_configured = 1'b1;
                w_state      = StIdle;
            end
            StErr: begin
                w_cs_n  = 1'b1;
                w_busy  = 1'b0;
                w_error = 1'b1;
                w_state = StIdle;
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_trig_q     <= 1'b0;
            r_div        <= '0;
            r_sclk       <= 1'b0;
            r_bit        <= 6'd0;
            r_tx         <= 32'd0;
            r_rx         <= 32'd0;
            r_cnt        <= 16'd0;
            r_cs_n       <= 1'b1;
            r_mosi       <= 1'b0;
            r_cfg_data   <= 32'd0;
            r_cfg_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_configured <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_trig_q     <= i_trigger;
            r_div        <= w_div;
            r_sclk       <= w_sclk;
            r_bit        <= w_bit;
            r_tx         <= w_tx;
            r_rx         <= w_rx;
            r_cnt        <= w_cnt;
            r_cs_n       <= w_cs_n;
            r_mosi       <= w_mosi;
            r_cfg_data   <= w_cfg_data;
            r_cfg_valid  <= w_cfg_valid;
            r_busy       <= w_busy;
            r_configured <= w_configured;
            r_error      <= w_error;
        end
    end

    assign io_bus.sclk      = r_sclk;
    assign io_bus.cs_n      = r_cs_n;
    assign io_bus.mosi      = r_mosi;
    assign io_bus.cfg_data  = r_cfg_data;
    assign io_bus.cfg_valid = r_cfg_valid;
    assign o_busy           = r_busy;
    assign o_configured     = r_configured;
    assign o_error          = r_error;
endmodule
